// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: counter encodings and
// RISC-V opcode constants used by fetch/decode stages that feed the predictor.
package bpu_pkg;

  // 2-bit saturating direction counter states.
  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } cnt_e;

  localparam logic [31:0] InstrNop  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [6:0]  OpcBranch = 7'b110_0011;
  localparam logic [6:0]  OpcJal    = 7'b110_1111;
  localparam logic [6:0]  OpcJalr   = 7'b110_0111;

  // Sequential fall-through address, wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
// master: the pipeline driving fetch/resolve info; slave: the predictor.
interface branch_predict_unit_if #(
  parameter int unsigned HIST_LEN = 6
);
  logic [31:0]         if_pc;
  logic                if_valid;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [HIST_LEN-1:0] pred_ghr;

  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic [31:0]         ex_target;
  logic                ex_is_branch;
  logic                ex_is_jump;
  logic                ex_taken;
  logic                ex_pred_taken;
  logic [31:0]         ex_pred_target;
  logic [HIST_LEN-1:0] ex_ghr;

  logic                flush;
  logic [31:0]         redirect_pc;
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output if_pc, if_valid, ex_valid, ex_pc, ex_target, ex_is_branch, ex_is_jump,
           ex_taken, ex_pred_taken, ex_pred_target, ex_ghr,
    input  pred_taken, pred_target, pred_ghr, flush, redirect_pc, stat_branches,
           stat_mispredicts
  );

  modport slave (
    input  if_pc, if_valid, ex_valid, ex_pc, ex_target, ex_is_branch, ex_is_jump,
           ex_taken, ex_pred_taken, ex_pred_target, ex_ghr,
    output pred_taken, pred_target, pred_ghr, flush, redirect_pc, stat_branches,
           stat_mispredicts
  );
endinterface

// File: rtl/bpu_sat_counter.sv
// Next-state of a 2-bit saturating direction counter (bounded at SNT and ST).
module bpu_sat_counter
  import bpu_pkg::*;
(
  input  cnt_e cnt_i,
  input  logic inc_i,
  output cnt_e cnt_o
);

  // Step toward taken or not-taken, holding at the bounds.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i && (cnt_i != CntSt)) begin
      cnt_o = cnt_e'(cnt_i + 2'd1);
    end else if (!inc_i && (cnt_i != CntSnt)) begin
      cnt_o = cnt_e'(cnt_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare-style direction predictor with a direct-mapped BTB. Prediction is
// combinational from if_pc; training and recovery happen from EX resolution.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned HIST_LEN = 6
) (
  input logic                  clk,
  input logic                  reset,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned Idx  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - Idx;

  typedef logic [Idx-1:0]  idx_t;
  typedef logic [TagW-1:0] tag_t;

  logic                btb_valid_q  [ENTRIES];
  tag_t                btb_tag_q    [ENTRIES];
  logic [31:0]         btb_target_q [ENTRIES];
  logic                btb_jump_q   [ENTRIES];
  cnt_e                cnt_q        [ENTRIES];
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_branches_q, stat_mispredicts_q;

  idx_t if_idx, if_pidx, ex_idx, ex_pidx;
  tag_t if_tag, ex_tag;
  logic hit, pred_taken, flush;
  logic ex_wr_btb, ex_upd_cnt, ex_ctrl;
  cnt_e cnt_upd;

  assign if_idx  = bus.if_pc[Idx+1:2];
  assign if_tag  = bus.if_pc[31:Idx+2];
  assign if_pidx = if_idx ^ idx_t'(ghr_q);
  assign ex_idx  = bus.ex_pc[Idx+1:2];
  assign ex_tag  = bus.ex_pc[31:Idx+2];
  assign ex_pidx = ex_idx ^ idx_t'(bus.ex_ghr);

  assign hit        = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
  assign pred_taken = hit && (btb_jump_q[if_idx] || (cnt_q[if_pidx] >= CntWt));

  assign flush = bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                                  (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

  assign ex_wr_btb  = bus.ex_valid && bus.ex_taken;
  assign ex_upd_cnt = bus.ex_valid && bus.ex_is_branch;
  assign ex_ctrl    = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);

  assign bus.pred_taken       = pred_taken;
  assign bus.pred_target      = pred_taken ? btb_target_q[if_idx] : pc_plus4(bus.if_pc);
  assign bus.pred_ghr         = ghr_q;
  assign bus.flush            = flush;
  assign bus.redirect_pc      = bus.ex_taken ? bus.ex_target : pc_plus4(bus.ex_pc);
  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

  bpu_sat_counter u_sat_counter (
    .cnt_i (cnt_q[ex_pidx]),
    .inc_i (bus.ex_taken),
    .cnt_o (cnt_upd)
  );

  // Speculative history shift on predicted conditional branches; recovery wins.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.if_valid && hit && !btb_jump_q[if_idx]) begin
      ghr_d    = ghr_q << 1;
      ghr_d[0] = pred_taken;
    end
    if (flush) begin
      if (bus.ex_is_branch) begin
        ghr_d    = bus.ex_ghr << 1;
        ghr_d[0] = bus.ex_taken;
      end else begin
        ghr_d = bus.ex_ghr;
      end
    end
  end

  // Reset-visible predictor state: valid bits, counters, history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        cnt_q[i]       <= CntWnt;
      end
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (ex_upd_cnt) cnt_q[ex_pidx] <= cnt_upd;
      if (ex_wr_btb) btb_valid_q[ex_idx] <= 1'b1;
    end
  end

  // BTB payload; only meaningful behind a valid bit, so no reset needed.
  always_ff @(posedge clk) begin
    if (reset && ex_wr_btb) begin
      btb_tag_q[ex_idx]    <= ex_tag;
      btb_target_q[ex_idx] <= bus.ex_target;
      btb_jump_q[ex_idx]   <= bus.ex_is_jump;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (ex_ctrl && (stat_branches_q != '1)) stat_branches_q <= stat_branches_q + 32'd1;
      if (flush && (stat_mispredicts_q != '1)) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus random
// traffic checked against a table-level behavioural model.
module tb_branch_predict_unit;

  localparam int unsigned ENTRIES  = 64;
  localparam int unsigned HIST_LEN = 6;
  localparam int unsigned IDXW     = 6;
  localparam int unsigned GMASK    = (1 << HIST_LEN) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.HIST_LEN(HIST_LEN)) bus ();

  branch_predict_unit #(.ENTRIES(ENTRIES), .HIST_LEN(HIST_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_cnt    [ENTRIES];
  int unsigned m_ghr;
  int unsigned m_br, m_mp;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int unsigned i = m_idx(pc);
    return m_hit(pc) && (m_jump[i] || (m_cnt[i ^ m_ghr] >= 2));
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_pred(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_flush();
    return bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  endfunction

  function automatic logic [31:0] m_redirect();
    return bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic m_clock();
    int unsigned g, i, k, e;
    bit p, fl;
    if (!reset) begin
      for (int n = 0; n < ENTRIES; n++) begin
        m_valid[n] = 0;
        m_cnt[n]   = 1;
      end
      m_ghr = 0; m_br = 0; m_mp = 0;
      return;
    end
    g  = m_ghr;
    i  = m_idx(bus.if_pc);
    p  = m_pred(bus.if_pc);
    fl = m_flush();
    if (bus.if_valid && m_hit(bus.if_pc) && !m_jump[i]) g = ((m_ghr << 1) | p) & GMASK;
    if (fl) g = bus.ex_is_branch ? (((int'(bus.ex_ghr) << 1) | bus.ex_taken) & GMASK)
                                 : int'(bus.ex_ghr);
    if (bus.ex_valid && bus.ex_is_branch) begin
      k = m_idx(bus.ex_pc) ^ int'(bus.ex_ghr);
      if (bus.ex_taken) m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
      else              m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
    end
    if (bus.ex_valid && bus.ex_taken) begin
      e = m_idx(bus.ex_pc);
      m_valid[e]  = 1;
      m_tag[e]    = m_tagof(bus.ex_pc);
      m_target[e] = bus.ex_target;
      m_jump[e]   = bus.ex_is_jump;
    end
    if (bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump) && m_br != 32'hFFFF_FFFF) m_br++;
    if (fl && m_mp != 32'hFFFF_FFFF) m_mp++;
    m_ghr = g;
  endtask

  task automatic set_if(input logic [31:0] pc, input bit v);
    bus.if_pc    = pc;
    bus.if_valid = v;
  endtask

  task automatic set_ex(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit br, input bit jmp, input bit tk, input bit ptk,
                        input logic [31:0] ptgt, input int unsigned g);
    logic [31:0] gv;
    gv                 = g;
    bus.ex_valid       = v;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_is_branch   = br;
    bus.ex_is_jump     = jmp;
    bus.ex_taken       = tk;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    bus.ex_ghr         = gv[HIST_LEN-1:0];
  endtask

  task automatic clear_ex();
    set_ex(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_ex();
    set_if(32'h0, 0);
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic test_reset();
    set_if(32'h100, 1);
    set_ex(1, 32'h100, 32'h900, 0, 1, 1, 0, 32'h0, 0);  // must be discarded
    reset = 1'b0;
    #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL reset_flush got %0b exp 1", bus.flush); end
    checks++; if (bus.redirect_pc !== 32'h900) begin errors++; $display("FAIL reset_redirect got %h exp 00000900", bus.redirect_pc); end
    tick();
    tick();
    reset = 1'b1;
    clear_ex();
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h exp 00000104", bus.pred_target); end
    checks++; if (bus.pred_ghr !== 6'h0) begin errors++; $display("FAIL reset_ghr got %h exp 00", bus.pred_ghr); end
    checks++; if (bus.stat_branches !== 32'h0) begin errors++; $display("FAIL reset_stat_br got %0d exp 0", bus.stat_branches); end
    checks++; if (bus.stat_mispredicts !== 32'h0) begin errors++; $display("FAIL reset_stat_mp got %0d exp 0", bus.stat_mispredicts); end
  endtask

  task automatic test_branch_train();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      set_ex(1, 32'h200, 32'h180, 1, 0, 1, 0, 32'h204, GMASK);
      #1;
      checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL train_flush%0d got %0b exp 1", n, bus.flush); end
      checks++; if (bus.redirect_pc !== 32'h180) begin errors++; $display("FAIL train_redirect%0d got %h exp 00000180", n, bus.redirect_pc); end
      tick();
    end
    clear_ex();
    set_if(32'h200, 0);
    #1;
    checks++; if (bus.pred_ghr !== 6'h3f) begin errors++; $display("FAIL train_ghr got %h exp 3f", bus.pred_ghr); end
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred got %0b exp 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h180) begin errors++; $display("FAIL train_target got %h exp 00000180", bus.pred_target); end
    checks++; if (bus.stat_branches !== 32'd2) begin errors++; $display("FAIL train_stat_br got %0d exp 2", bus.stat_branches); end
    checks++; if (bus.stat_mispredicts !== 32'd2) begin errors++; $display("FAIL train_stat_mp got %0d exp 2", bus.stat_mispredicts); end
  endtask

  task automatic test_jal();
    do_reset();
    set_ex(1, 32'h40, 32'h400, 0, 1, 1, 0, 32'h44, 0);
    #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL jal_flush got %0b exp 1", bus.flush); end
    tick();
    clear_ex();
    set_if(32'h40, 1);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL jal_pred got %0b exp 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h400) begin errors++; $display("FAIL jal_target got %h exp 00000400", bus.pred_target); end
    tick();
    set_if(32'h40, 0);
    #1;
    checks++; if (bus.pred_ghr !== 6'h0) begin errors++; $display("FAIL jal_ghr_hold got %h exp 00", bus.pred_ghr); end
    checks++; if (bus.stat_branches !== 32'd1) begin errors++; $display("FAIL jal_stat_br got %0d exp 1", bus.stat_branches); end
  endtask

  task automatic test_counter_sat();
    bit ops [6];
    bit expv [6];
    ops  = '{0, 0, 0, 0, 1, 1};
    expv = '{1, 0, 0, 0, 0, 1};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      set_ex(1, 32'h300, 32'h340, 1, 0, 1, 1, 32'h340, 0);
      tick();
    end
    clear_ex();
    set_if(32'h300, 0);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_top got %0b exp 1", bus.pred_taken); end
    for (int n = 0; n < 6; n++) begin
      set_ex(1, 32'h300, 32'h340, 1, 0, ops[n], ops[n], 32'h340, 0);
      tick();
      clear_ex();
      set_if(32'h300, 0);
      #1;
      checks++; if (bus.pred_taken !== expv[n]) begin errors++; $display("FAIL sat_step%0d got %0b exp %0b", n, bus.pred_taken, expv[n]); end
    end
    // Not-taken branch aliasing an existing entry must neither allocate nor evict.
    for (int n = 0; n < 3; n++) begin
      set_ex(1, 32'h044, 32'h900, 1, 0, 1, 1, 32'h900, 0);
      tick();
    end
    set_ex(1, 32'h744, 32'h980, 1, 0, 0, 0, 32'h0, 0);
    tick();
    clear_ex();
    set_if(32'h044, 0);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL nt_keep_pred got %0b exp 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h900) begin errors++; $display("FAIL nt_keep_target got %h exp 00000900", bus.pred_target); end
    set_if(32'h744, 0);
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL nt_noalloc_pred got %0b exp 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h748) begin errors++; $display("FAIL nt_noalloc_target got %h exp 00000748", bus.pred_target); end
  endtask

  task automatic test_alias();
    do_reset();
    set_ex(1, 32'h100, 32'hA00, 0, 1, 1, 0, 32'h0, 0);
    tick();
    set_ex(1, 32'h100 + 4 * ENTRIES, 32'hB00, 0, 1, 1, 0, 32'h0, 0);
    tick();
    clear_ex();
    set_if(32'h100 + 4 * ENTRIES, 0);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred got %0b exp 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'hB00) begin errors++; $display("FAIL alias_new_target got %h exp 00000b00", bus.pred_target); end
    set_if(32'h100, 0);
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_pred got %0b exp 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h104) begin errors++; $display("FAIL alias_old_target got %h exp 00000104", bus.pred_target); end
  endtask

  task automatic test_flush_ghr();
    do_reset();
    set_ex(1, 32'h80, 32'h90, 1, 0, 1, 1, 32'h90, 0);
    tick();
    set_if(32'h80, 1);
    set_ex(1, 32'h1000, 32'h1100, 1, 0, 1, 0, 32'h1004, 6'b101010);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL fghr_hit got %0b exp 1", bus.pred_taken); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL fghr_flush got %0b exp 1", bus.flush); end
    tick();
    clear_ex();
    #1;
    checks++; if (bus.pred_ghr !== 6'b010101) begin errors++; $display("FAIL fghr_recover got %b exp 010101", bus.pred_ghr); end
    checks++; if (bus.stat_mispredicts !== 32'd1) begin errors++; $display("FAIL fghr_stat_mp got %0d exp 1", bus.stat_mispredicts); end
    tick();
    set_if(32'h80, 0);
    #1;
    checks++; if (bus.pred_ghr !== 6'b101010) begin errors++; $display("FAIL fghr_shift got %b exp 101010", bus.pred_ghr); end
  endtask

  task automatic test_random();
    int unsigned kind;
    logic [31:0] tgt;
    bit br, jmp, tk;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      br   = kind < 6;
      jmp  = (kind == 6) || (kind == 7);
      tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      tgt  = rnd_pc() + 32'h1000;
      set_if(rnd_pc(), 1'($urandom_range(0, 1)));
      set_ex($urandom_range(0, 3) != 0, rnd_pc(), tgt, br, jmp, tk, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? tgt : rnd_pc() + 32'h1000,
             ($urandom_range(0, 1) != 0) ? m_ghr : $urandom_range(0, GMASK));
      #1;
      checks++; if (bus.pred_taken !== m_pred(bus.if_pc)) begin errors++; $display("FAIL rnd_pred[%0d] got %0b exp %0b", n, bus.pred_taken, m_pred(bus.if_pc)); end
      checks++; if (bus.pred_target !== m_ptarget(bus.if_pc)) begin errors++; $display("FAIL rnd_target[%0d] got %h exp %h", n, bus.pred_target, m_ptarget(bus.if_pc)); end
      checks++; if (bus.pred_ghr !== HIST_LEN'(m_ghr)) begin errors++; $display("FAIL rnd_ghr[%0d] got %h exp %h", n, bus.pred_ghr, HIST_LEN'(m_ghr)); end
      checks++; if (bus.flush !== m_flush()) begin errors++; $display("FAIL rnd_flush[%0d] got %0b exp %0b", n, bus.flush, m_flush()); end
      checks++; if (bus.redirect_pc !== m_redirect()) begin errors++; $display("FAIL rnd_redirect[%0d] got %h exp %h", n, bus.redirect_pc, m_redirect()); end
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick();
      reset = 1'b1;
      checks++; if (bus.stat_branches !== m_br) begin errors++; $display("FAIL rnd_stat_br[%0d] got %0d exp %0d", n, bus.stat_branches, m_br); end
      checks++; if (bus.stat_mispredicts !== m_mp) begin errors++; $display("FAIL rnd_stat_mp[%0d] got %0d exp %0d", n, bus.stat_mispredicts, m_mp); end
    end
  endtask

  initial begin
    clear_ex();
    set_if(32'h0, 0);
    test_reset();
    test_branch_train();
    test_jal();
    test_counter_sat();
    test_alias();
    test_flush_ghr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of predictor/BTB entries (power of 2, 4..1024).
REQ-002 SHALL have parameter HIST_LEN, default 6, global history bits (1..log2(ENTRIES)).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port if_pc  input  32  fetch PC.
REQ-006 SHALL have port if_valid  input  1  fetch advances this cycle (low during load stall).
REQ-007 SHALL have port pred_taken  output  1  predicted taken.
REQ-008 SHALL have port pred_target  output  32  next fetch PC.
REQ-009 SHALL have port pred_ghr  output  HIST_LEN  history snapshot, carried down pipeline with the instruction.
REQ-010 SHALL have port ex_valid  input  1  EX holds a resolved control-flow instruction.
REQ-011 SHALL have port ex_pc / ex_target  input  32 each  resolved PC and computed target.
REQ-012 SHALL have ports ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken  input  1 each  conditional branch, JAL/JALR, actual outcome, carried prediction.
REQ-013 SHALL have ports ex_pred_target  input  32 and ex_ghr  input  HIST_LEN  carried predicted target and snapshot.
REQ-014 SHALL have ports flush  output  1 and redirect_pc  output  32  mispredict recovery.
REQ-015 SHALL have ports stat_branches, stat_mispredicts  output  32 each  event counters.

Function
REQ-016 SHALL compute idx = if_pc[IDX+1:2] (IDX=log2 ENTRIES), tag = if_pc[31:IDX+2], pidx = idx XOR zero-extended GHR.
REQ-017 SHALL hold per entry: BTB valid, tag, 32-bit target, jump flag; separate 2-bit saturating counter array indexed by pidx.
REQ-018 SHALL define hit = valid[idx] and tag match; pred_taken = hit and (jump flag or counter[pidx] >= 2).
REQ-019 SHALL drive pred_target = BTB target when pred_taken, else if_pc+4 (mod 2^32), combinationally, same cycle as if_pc.
REQ-020 SHALL drive pred_ghr = current GHR, combinationally.
REQ-021 SHALL shift pred_taken into GHR LSB on if_valid and hit and jump flag clear; GHR otherwise unchanged.
REQ-022 SHALL assert flush combinationally when ex_valid and (ex_taken != ex_pred_taken or (ex_taken and ex_target != ex_pred_target)).
REQ-023 SHALL drive redirect_pc = ex_target if ex_taken, else ex_pc+4.
REQ-024 SHALL, on flush, load GHR with {ex_ghr[HIST_LEN-2:0], ex_taken} for branches, ex_ghr for jumps; overrides REQ-021 same cycle.
REQ-025 SHALL, on ex_valid and ex_is_branch, saturate-increment counter[ex_pc idx XOR ex_ghr] if taken, else saturate-decrement (00 and 11 are bounds).
REQ-026 SHALL, on ex_valid and ex_taken, write BTB entry at ex_pc idx: valid=1, tag, target=ex_target, jump flag=ex_is_jump (replaces any aliasing entry).
REQ-027 SHALL NOT allocate on not-taken branch; an existing entry stays valid.
REQ-028 SHALL give same-cycle read/update of one entry the pre-update value (no bypass).
REQ-029 SHALL ignore all ex_* inputs when ex_valid is low.
REQ-030 SHALL increment stat_branches on ex_valid and (ex_is_branch or ex_is_jump), stat_mispredicts on flush; both saturate at 0xFFFFFFFF.

Reset
REQ-031 SHALL, while reset is low at a clock edge, clear all BTB valid bits, set all counters to 01, GHR to 0, stats to 0; completes in one cycle.
REQ-032 SHALL give outputs after reset: pred_taken=0, pred_target=if_pc+4, pred_ghr=0, stats=0; flush/redirect_pc follow ex_* inputs.
REQ-033 SHALL discard an ex update in a reset cycle.

Structure
REQ-034 SHALL place counter encodings (SNT=00, WNT=01, WT=10, ST=11), NOP and opcode constants in shared package bpu_pkg.
REQ-035 SHALL implement the 2-bit update in sub-module bpu_sat_counter.

Verification
REQ-036 Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, stats=0.
REQ-037 Branch at 0x200, target 0x180, resolved taken twice (pred 0) -> flush both times, redirect 0x180; then fetch 0x200 with matching GHR -> pred_taken=1, target 0x180.
REQ-038 JAL at 0x40 to 0x400, resolved once -> next fetch 0x40 pred_taken=1, pred_target=0x400 regardless of counter.
REQ-039 Counter at ST, four not-taken updates -> 11,10,01,00,00; prediction not-taken after second.
REQ-040 Aliasing PCs 0x100 and 0x100+4*ENTRIES both taken -> later allocation wins; 0x100 misses tag.
REQ-041 Mispredict with ex_ghr=0b101010, taken -> GHR=0b010101 next cycle despite if_valid hit same cycle; stat_mispredicts +1.
